// File: rtl/pvt_uart_ctrl_if.sv
// Handshake bundle between the PVT command controller, the UART RX/TX pair and the sensor bank.
interface pvt_uart_ctrl_if #(
   parameter int N_SENSORS = 3,
   parameter int RESULT_W  = 16
) ();
   logic                          rx_valid;
   logic [7:0]                    rx_data;
   logic                          tx_busy;
   logic                          tx_start;
   logic [7:0]                    tx_data;
   logic [N_SENSORS-1:0]          meas_start;
   logic [N_SENSORS-1:0]          meas_done;
   logic [N_SENSORS*RESULT_W-1:0] meas_result;

   modport master (
      input  rx_valid, rx_data, tx_busy, meas_done, meas_result,
      output tx_start, tx_data, meas_start
   );

   modport slave (
      output rx_valid, rx_data, tx_busy, meas_done, meas_result,
      input  tx_start, tx_data, meas_start
   );
endinterface

// File: rtl/pvt_uart_ctrl.sv
// Host command controller: decodes one UART command byte, triggers a PVT sensor and streams the reply.
// Define PVT_CTRL_CHECKSUM_EN to append an XOR checksum byte to every reply.
module pvt_uart_ctrl #(
   parameter int N_SENSORS = 3,
   parameter int RESULT_W  = 16,
   parameter int TIMEOUT   = 1023
) (
   input  logic            clk,
   input  logic            rst_n,
   pvt_uart_ctrl_if.master bus,
   output logic            busy,
   output logic            overrun
);
   localparam int         CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [3:0] OP_PING   = 4'h5;
   localparam logic [3:0] OP_MEAS   = 4'hA;
   localparam logic [7:0] REPLY_ERR = 8'hEE;
   localparam logic [7:0] REPLY_TMO = 8'hEF;
`ifdef PVT_CTRL_CHECKSUM_EN
   localparam logic [2:0] LEN_SHORT = 3'd2;
   localparam logic [2:0] LEN_LONG  = 3'd4;
`else
   localparam logic [2:0] LEN_SHORT = 3'd1;
   localparam logic [2:0] LEN_LONG  = 3'd3;
`endif

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      DECODE     = 3'd1,
      MEAS_START = 3'd2,
      MEAS_WAIT  = 3'd3,
      SEND       = 3'd4,
      GUARD      = 3'd5,
      SEND_WAIT  = 3'd6
   } state_t;

   function automatic logic [7:0] xor_sum(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2);
      return b0 ^ b1 ^ b2;
   endfunction

   function automatic logic [3:0][7:0] frame_short(input logic [7:0] b0);
      logic [3:0][7:0] f;
      f    = '0;
      f[0] = b0;
`ifdef PVT_CTRL_CHECKSUM_EN
      f[1] = xor_sum(b0, 8'h00, 8'h00);
`endif
      return f;
   endfunction

   function automatic logic [3:0][7:0] frame_long(input logic [7:0] b0, input logic [7:0] b1,
                                                  input logic [7:0] b2);
      logic [3:0][7:0] f;
      f    = '0;
      f[0] = b0;
      f[1] = b1;
      f[2] = b2;
`ifdef PVT_CTRL_CHECKSUM_EN
      f[3] = xor_sum(b0, b1, b2);
`endif
      return f;
   endfunction

   state_t               state_r, state_s;
   logic [7:0]           cmd_r, cmd_s;
   logic [3:0][7:0]      buf_r, buf_s;
   logic [2:0]           len_r, len_s;
   logic [2:0]           idx_r, idx_s;
   logic [2:0]           idx_inc_s;
   logic [CNT_W-1:0]     cnt_r, cnt_s;
   logic [7:0]           tx_data_r, tx_data_s;
   logic [N_SENSORS-1:0] meas_start_r, meas_start_s;
   logic                 busy_r;
   logic                 overrun_r, overrun_s;
   logic                 tx_start_s;
   logic [N_SENSORS-1:0] sel_onehot_s;
   logic                 done_sel_s;
   logic [RESULT_W-1:0]  res_sel_s;
   logic [15:0]          res16_s;
   logic                 idx_ok_s;
   logic [7:0]           short_byte_s;

   assign res16_s      = 16'(res_sel_s);
   assign idx_ok_s     = ({1'b0, cmd_r[3:0]} < 5'(N_SENSORS));
   assign short_byte_s = (cmd_r[7:4] == OP_PING) ? cmd_r : REPLY_ERR;
   assign idx_inc_s    = idx_r + 3'd1;

   // Addressed-sensor select: trigger mask, done pulse and result slice for cmd_r[3:0].
   always_comb begin
      sel_onehot_s = '0;
      done_sel_s   = 1'b0;
      res_sel_s    = '0;
      for (int s = 0; s < N_SENSORS; s++) begin
         sel_onehot_s[s] = (cmd_r[3:0] == 4'(s));
         done_sel_s      = done_sel_s | (sel_onehot_s[s] & bus.meas_done[s]);
         res_sel_s       = res_sel_s |
                           ({RESULT_W{sel_onehot_s[s]}} & bus.meas_result[s*RESULT_W +: RESULT_W]);
      end
   end

   // Command FSM next-state and datapath loads; tx_data is reloaded on every entry into SEND.
   always_comb begin
      state_s      = state_r;
      cmd_s        = cmd_r;
      buf_s        = buf_r;
      len_s        = len_r;
      idx_s        = idx_r;
      cnt_s        = cnt_r;
      tx_data_s    = tx_data_r;
      meas_start_s = '0;
      tx_start_s   = 1'b0;
      overrun_s    = overrun_r | (bus.rx_valid & (state_r != IDLE));
      case (state_r)
         IDLE: begin
            if (bus.rx_valid) begin
               cmd_s   = bus.rx_data;
               state_s = DECODE;
            end else begin
               state_s = IDLE;
            end
         end
         DECODE: begin
            idx_s = 3'd0;
            if ((cmd_r[7:4] == OP_MEAS) && idx_ok_s) begin
               meas_start_s = sel_onehot_s;
               state_s      = MEAS_START;
            end else begin
               buf_s     = frame_short(short_byte_s);
               len_s     = LEN_SHORT;
               tx_data_s = short_byte_s;
               state_s   = SEND;
            end
         end
         MEAS_START: begin
            cnt_s   = '0;
            state_s = MEAS_WAIT;
         end
         MEAS_WAIT: begin
            // A done pulse coinciding with expiry still reports the measurement.
            if (done_sel_s) begin
               buf_s     = frame_long(cmd_r, res16_s[15:8], res16_s[7:0]);
               len_s     = LEN_LONG;
               tx_data_s = cmd_r;
               state_s   = SEND;
            end else if (cnt_r == CNT_W'(TIMEOUT)) begin
               buf_s     = frame_short(REPLY_TMO);
               len_s     = LEN_SHORT;
               tx_data_s = REPLY_TMO;
               state_s   = SEND;
            end else begin
               cnt_s   = cnt_r + CNT_W'(1);
               state_s = MEAS_WAIT;
            end
         end
         SEND: begin
            if (!bus.tx_busy) begin
               tx_start_s = 1'b1;
               state_s    = GUARD;
            end else begin
               state_s = SEND;
            end
         end
         GUARD: begin
            state_s = SEND_WAIT;
         end
         SEND_WAIT: begin
            if (!bus.tx_busy) begin
               idx_s = idx_inc_s;
               if (idx_inc_s == len_r) begin
                  state_s = IDLE;
               end else begin
                  tx_data_s = buf_r[idx_inc_s[1:0]];
                  state_s   = SEND;
               end
            end else begin
               state_s = SEND_WAIT;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         cmd_r        <= 8'h00;
         buf_r        <= '0;
         len_r        <= 3'd0;
         idx_r        <= 3'd0;
         cnt_r        <= '0;
         tx_data_r    <= 8'h00;
         meas_start_r <= '0;
         busy_r       <= 1'b0;
         overrun_r    <= 1'b0;
      end else begin
         state_r      <= state_s;
         cmd_r        <= cmd_s;
         buf_r        <= buf_s;
         len_r        <= len_s;
         idx_r        <= idx_s;
         cnt_r        <= cnt_s;
         tx_data_r    <= tx_data_s;
         meas_start_r <= meas_start_s;
         busy_r       <= (state_s != IDLE);
         overrun_r    <= overrun_s;
      end
   end

   // tx_start is decoded from SEND and the live tx_busy so the launch lands in the first SEND cycle.
   assign bus.tx_start   = tx_start_s;
   assign bus.tx_data    = tx_data_r;
   assign bus.meas_start = meas_start_r;
   assign busy           = busy_r;
   assign overrun        = overrun_r;
endmodule

// File: tb/tb_pvt_uart_ctrl.sv
// Directed table-driven bench for pvt_uart_ctrl with a UART TX model and a sensor-bank model.
module tb_pvt_uart_ctrl;
   localparam int NS  = 3;
   localparam int RW  = 16;
   localparam int TMO = 15;

   typedef struct {
      logic [7:0]    cmd;
      int            delay;
      logic [15:0]   result;
      int            nb;
      logic [7:0]    b0;
      logic [7:0]    b1;
      logic [7:0]    b2;
      logic [NS-1:0] ms;
      int            lat;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          busy;
   logic          overrun;
   logic          tx_busy_m = 1'b0;
   logic [NS-1:0] done_m = '0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rx_cyc = 0;
   int cur_delay = -1;

   logic [7:0]    txq[$];
   int            txcyc[$];
   int            busy_left = 0;
   logic          arm = 1'b0;
   logic          fire;

   int            ms_cnt = 0;
   int            ms_cyc = 0;
   int            ms_idx = 0;
   logic [NS-1:0] ms_val = '0;
   int            done_left = 0;
   int            decoy_left = 0;

   vec_t vecs[10];

   always #5 clk = ~clk;

   pvt_uart_ctrl_if #(.N_SENSORS(NS), .RESULT_W(RW)) bus ();

   assign bus.tx_busy   = tx_busy_m;
   assign bus.meas_done = done_m;

   pvt_uart_ctrl #(.N_SENSORS(NS), .RESULT_W(RW), .TIMEOUT(TMO)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .busy    (busy),
      .overrun (overrun)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // UART TX model: busy rises the cycle after tx_start and stays high for three cycles.
   always @(posedge clk) begin
      #1;
      fire = bus.tx_start;
      if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) tx_busy_m = 1'b0;
      end
      if (arm) begin
         tx_busy_m = 1'b1;
         busy_left = 3;
      end
      arm = (fire === 1'b1);
      if (fire === 1'b1) begin
         txq.push_back(bus.tx_data);
         txcyc.push_back(cyc);
      end
   end

   // Sensor model: done after cur_delay cycles plus a decoy done on a neighbouring sensor.
   always @(posedge clk) begin
      #1;
      done_m = '0;
      if (done_left > 0) begin
         done_left--;
         if (done_left == 0) done_m[ms_idx] = 1'b1;
      end
      if (decoy_left > 0) begin
         decoy_left--;
         if (decoy_left == 0) done_m[(ms_idx + 1) % NS] = 1'b1;
      end
      if (bus.meas_start != '0) begin
         ms_cnt++;
         ms_val = bus.meas_start;
         ms_cyc = cyc;
         for (int s = 0; s < NS; s++) if (bus.meas_start[s]) ms_idx = s;
         done_left  = (cur_delay > 0) ? cur_delay : 0;
         decoy_left = 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic set_results(input logic [7:0] cmd, input logic [15:0] res);
      for (int s = 0; s < NS; s++)
         bus.meas_result[s*RW +: RW] = (s == int'(cmd[3:0])) ? res : 16'hDEAD;
   endtask

   task automatic send_cmd(input logic [7:0] c);
      @(negedge clk);
      bus.rx_data  = c;
      bus.rx_valid = 1'b1;
      rx_cyc       = cyc;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({name, "_idle"}, (n < 400) ? 32'd1 : 32'd0, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   // Leaves the bench at the negedge of the first SEND_WAIT cycle of a reply.
   task automatic wait_send_wait(input int base, input string name);
      int n;
      n = 0;
      while (!(txq.size() > base && tx_busy_m) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({name, "_first_byte"}, (n < 200) ? 32'd1 : 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic check_reply(input string name, input int base, input int nb,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      logic [7:0] exp[4];
      int n;
      n = nb;
      exp[0] = b0;
      exp[1] = b1;
      exp[2] = b2;
      exp[3] = 8'h00;
`ifdef PVT_CTRL_CHECKSUM_EN
      exp[n] = b0 ^ b1 ^ b2;
      n++;
`endif
      check({name, "_nbytes"}, txq.size() - base, n);
      for (int k = 0; k < n; k++)
         check($sformatf("%s_byte%0d", name, k), (base + k < txq.size()) ? txq[base + k] : 8'h00,
               exp[k]);
   endtask

   task automatic run_vector(input vec_t t);
      int    base_q;
      int    base_ms;
      string nm;
      nm        = $sformatf("cmd%02h_d%0d", t.cmd, t.delay);
      cur_delay = t.delay;
      set_results(t.cmd, t.result);
      base_q  = txq.size();
      base_ms = ms_cnt;
      send_cmd(t.cmd);
      check({nm, "_busy"}, busy, 1);
      wait_idle(nm);
      check_reply(nm, base_q, t.nb, t.b0, t.b1, t.b2);
      if (txq.size() > base_q) check({nm, "_tx_lat"}, txcyc[base_q] - rx_cyc, t.lat);
      check({nm, "_ms_count"}, ms_cnt - base_ms, (t.ms != '0) ? 1 : 0);
      if (t.ms != '0) begin
         check({nm, "_ms_val"}, ms_val, t.ms);
         check({nm, "_ms_lat"}, ms_cyc - rx_cyc, 2);
      end
   endtask

   initial begin
      int base;
      //            cmd    delay result    nb b0     b1     b2     ms      lat
      vecs[0] = '{8'h50, -1, 16'h0000, 1, 8'h50, 8'h00, 8'h00, 3'b000, 2};
      vecs[1] = '{8'h5F, -1, 16'h0000, 1, 8'h5F, 8'h00, 8'h00, 3'b000, 2};
      vecs[2] = '{8'hA1, 10, 16'h1234, 3, 8'hA1, 8'h12, 8'h34, 3'b010, 13};
      vecs[3] = '{8'hA0, 1,  16'hBEEF, 3, 8'hA0, 8'hBE, 8'hEF, 3'b001, 4};
      vecs[4] = '{8'hA2, -1, 16'h0000, 1, 8'hEF, 8'h00, 8'h00, 3'b100, 19};
      vecs[5] = '{8'hA7, -1, 16'h0000, 1, 8'hEE, 8'h00, 8'h00, 3'b000, 2};
      vecs[6] = '{8'h30, -1, 16'h0000, 1, 8'hEE, 8'h00, 8'h00, 3'b000, 2};
      vecs[7] = '{8'hA3, -1, 16'h0000, 1, 8'hEE, 8'h00, 8'h00, 3'b000, 2};
      vecs[8] = '{8'hA2, 16, 16'h5678, 3, 8'hA2, 8'h56, 8'h78, 3'b100, 19};
      vecs[9] = '{8'hA2, 17, 16'h5678, 1, 8'hEF, 8'h00, 8'h00, 3'b100, 19};

      bus.rx_valid    = 1'b0;
      bus.rx_data     = 8'h00;
      bus.meas_result = '0;
      rst_n           = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx_start", bus.tx_start, 0);
      check("rst_tx_data", bus.tx_data, 8'h00);
      check("rst_meas_start", bus.meas_start, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 10; v++) run_vector(vecs[v]);
      check("no_overrun_after_table", overrun, 0);

      // Byte arriving during SEND_WAIT of a measure reply is dropped and flagged.
      cur_delay = 3;
      set_results(8'hA1, 16'h1234);
      base = txq.size();
      send_cmd(8'hA1);
      wait_send_wait(base, "ovr");
      bus.rx_data  = 8'h50;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      check("ovr_flag", overrun, 1);
      wait_idle("ovr");
      repeat (10) @(negedge clk);
      check_reply("ovr", base, 3, 8'hA1, 8'h12, 8'h34);
      check("ovr_still_idle", busy, 0);

      // Reset asserted in SEND_WAIT clears everything at the next edge.
      base = txq.size();
      send_cmd(8'hA1);
      wait_send_wait(base, "rstmid");
      rst_n = 1'b0;
      @(negedge clk);
      check("rstmid_tx_start", bus.tx_start, 0);
      check("rstmid_tx_data", bus.tx_data, 8'h00);
      check("rstmid_meas_start", bus.meas_start, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_overrun", overrun, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("rstmid_no_more_tx", txq.size() - base, 1);
      base = txq.size();
      cur_delay = -1;
      send_cmd(8'h50);
      wait_idle("rstmid_ping");
      check_reply("rstmid_ping", base, 1, 8'h50, 8'h00, 8'h00);

      // Second byte landing in the DECODE cycle is dropped.
      base = txq.size();
      @(negedge clk);
      bus.rx_data  = 8'h50;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_data  = 8'h5A;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      check("dec_overrun", overrun, 1);
      wait_idle("dec");
      check_reply("dec", base, 1, 8'h50, 8'h00, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pvt_uart_ctrl.md
# pvt_uart_ctrl

Command controller between `uart_rx`, `uart_tx` and the PVT sensor bank. It decodes single-byte host commands from the receiver and triggers the addressed process, voltage or temperature sensor. It waits for the measurement with a timeout, then streams a framed multi-byte reply through the shared transmitter. Only one command is in flight at a time; bytes arriving mid-command are dropped and flagged.

## Interface
- `N_SENSORS`, default 3: number of sensors; indices 0..N_SENSORS-1, max 16.
- `RESULT_W`, default 16: sensor result width, at most 16; zero-extended to 16 bits in replies.
- `TIMEOUT`, default 1023: maximum number of MEAS_WAIT cycles before a timeout reply.

- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `rx_valid` in 1: one-cycle pulse; `rx_data` is valid.
- `rx_data` in 8: received byte.
- `tx_busy` in 1: transmitter busy; must rise the cycle after `tx_start`.
- `tx_start` out 1: one-cycle pulse; launch `tx_data`.
- `tx_data` out 8: byte to transmit; held until the next load.
- `meas_start` out N_SENSORS: one-hot, one-cycle measurement trigger.
- `meas_done` in N_SENSORS: per-sensor done pulse.
- `meas_result` in N_SENSORS*RESULT_W: sensor i occupies bits [i*RESULT_W +: RESULT_W].
- `busy` out 1: high whenever the state is not IDLE.
- `overrun` out 1: sticky flag; a byte was dropped. Cleared only by reset.

## Operation
- Command byte `cmd` splits into opcode `cmd[7:4]` and index `cmd[3:0]`:
  - opcode 0x5 (ping): reply is `cmd`.
  - opcode 0xA (measure), index < N_SENSORS: reply is `cmd`, result[15:8], result[7:0].
  - opcode 0xA, index ≥ N_SENSORS, or any other opcode: reply is 0xEE.
  - measure timeout: reply is 0xEF.
- Reply buffer holds up to 4 bytes, with length register `len` and index `i`.
- States:
  - IDLE: on `rx_valid`, latch `cmd` → DECODE.
  - DECODE: load reply buffer for ping or error → SEND; valid measure → MEAS_START.
  - MEAS_START: assert `meas_start[idx]` for one cycle; clear timeout counter → MEAS_WAIT.
  - MEAS_WAIT: on `meas_done[idx]`, sample `meas_result` slice and load buffer → SEND. If counter == TIMEOUT, load 0xEF → SEND. Otherwise increment counter.
  - SEND: when `tx_busy`==0, drive `tx_data`=buf[i] and pulse `tx_start` → GUARD. When `tx_busy`==1, stay in SEND.
  - GUARD: one cycle; `tx_busy` ignored → SEND_WAIT.
  - SEND_WAIT: when `tx_busy`==0, do i+1; → IDLE if i+1==len, else → SEND.
- `meas_done` from non-addressed sensors is ignored.
- `meas_done[idx]` in the same cycle as timeout expiry: done wins.
- `rx_valid` in any state other than IDLE: byte dropped and `overrun` set. This includes the DECODE cycle.
- `rx_valid` in IDLE in the same cycle the FSM returns to IDLE: not possible, since the return to IDLE occurs at the edge; the byte is accepted on the next IDLE cycle.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0x00, `meas_start`=0, `busy`=0, `overrun`=0; state=IDLE, counters=0.
- Reset during any state takes effect at the next edge. No further `tx_start` or `meas_start` pulses are issued.
- `rx_valid` at edge k → DECODE at k+1 → `meas_start` high during k+2 (measure command).
- `rx_valid` at edge k → earliest `tx_start` during cycle k+2 (ping or error).
- `meas_done` at cycle m → first `tx_start` during cycle m+1 if the transmitter is idle.
- Back-to-back bytes: next `tx_start` no earlier than 1 cycle after `tx_busy` falls.
- Timeout fires after TIMEOUT+1 MEAS_WAIT cycles without done.

## Configuration
- `PVT_CTRL_CHECKSUM_EN` defined: every reply gets a trailing byte equal to the XOR of all preceding reply bytes, so `len` is 2, 4 or 2 for ping, measure and error replies.
- Undefined: no checksum byte; `len` is 1, 3 or 1.

## Test plan
- Ping: `rx_data`=0x50 → `tx_data` 0x50, one `tx_start`. With checksum: 0x50, 0x50.
- Measure: `rx_data`=0xA1, `meas_done[1]` 10 cycles after trigger, result 0x1234 → `meas_start`=3'b010 for exactly one cycle. Reply 0xA1, 0x12, 0x34; with checksum, 0x87 appended.
- Bad index and bad opcode: 0xA7 → 0xEE and `meas_start` never asserted. 0x30 → 0xEE.
- Timeout: 0xA2 with TIMEOUT=15 and no done → 0xEF. `tx_start` occurs 17 cycles after `meas_start`, given an idle transmitter.
- Overrun: `rx_valid` with 0x50 during SEND_WAIT of a measure reply → `overrun`=1. Reply bytes unchanged, no extra reply.
- Reset mid-reply: `rst_n`=0 in SEND_WAIT → next edge all outputs at reset values. After release, ping 0x50 works normally.
